// File: rtl/backdoor_pkg.sv
// Shared types for the backdoor memory sequencer: FSM states, target select, request word.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package backdoor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SP_WR,
        SP_RD,
        SP_RDW,
        FL_XFER,
        FL_RDW,
        RSP
    } state_e;

    typedef enum logic {
        TGT_SP = 1'b0,
        TGT_FL = 1'b1
    } tgt_e;

    typedef struct packed {
        logic        write;
        tgt_e        sel;
        logic [31:0] addr;
        logic [63:0] wdata;
    } req_t;

    localparam logic [7:0] SP_FULL_MASK = 8'hFF;

endpackage

// File: rtl/backdoor_req_fifo.sv
// Generic synchronous FIFO of type T; head entry is always visible on pop_dat.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: full refuses a push unless a pop is accepted in the same cycle.
module backdoor_req_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic core_clk,
    input  logic rstn,
    input  logic push_vld,
    input  T     push_dat,
    input  logic pop,
    output T     pop_dat,
    output logic full,
    output logic empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign pop_dat = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push_vld && (!full || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge core_clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload storage carries no reset; occupancy is tracked by cnt_q alone.
    always_ff @(posedge core_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/backdoor_mem_sequencer.sv
// Serialises backdoor requests onto a 64-bit scratchpad or a byte-wide flash, one at a time, in order.
// Latency from pop: SP write 2, SP read 3, misaligned SP 1, flash write 9, flash read 10 cycles.
// Backpressure: req_ready drops when the request FIFO is full; a held target stalls the head; no rsp backpressure.
module backdoor_mem_sequencer
    import backdoor_pkg::*;
#(
    parameter int SP_ADDR_W  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic                 req_sel,
    input  logic [31:0]          req_addr,
    input  logic [63:0]          req_wdata,
    output logic                 rsp_valid,
    output logic                 rsp_err,
    output logic [63:0]          rsp_rdata,
    input  logic                 sp_hold,
    input  logic                 fl_hold,
    output logic                 sp_en,
    output logic                 sp_write,
    output logic [7:0]           sp_mask,
    output logic [SP_ADDR_W-1:0] sp_addr,
    output logic [63:0]          sp_wdata,
    input  logic [63:0]          sp_rdata,
    output logic                 fl_en,
    output logic                 fl_we,
    output logic [31:0]          fl_addr,
    output logic [7:0]           fl_wdata,
    input  logic [7:0]           fl_rdata
);

    req_t push_dat, head;
    logic push_vld, pop_vld, full, empty, head_hold;

    state_e               state_q, state_d;
    logic                 xfer_write_q, xfer_write_d;
    logic [31:0]          xfer_addr_q, xfer_addr_d;
    logic [63:0]          xfer_wdata_q, xfer_wdata_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [55:0]          buf_q, buf_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [63:0]          rsp_rdata_q, rsp_rdata_d;
    logic                 sp_en_q, sp_en_d, sp_write_q, sp_write_d;
    logic [7:0]           sp_mask_q, sp_mask_d;
    logic [SP_ADDR_W-1:0] sp_addr_q, sp_addr_d;
    logic [63:0]          sp_wdata_q, sp_wdata_d;
    logic                 fl_en_q, fl_en_d, fl_we_q, fl_we_d;
    logic [31:0]          fl_addr_q, fl_addr_d;
    logic [7:0]           fl_wdata_q, fl_wdata_d;

    // Gating with rstn keeps the handshake closed for the whole reset window.
    assign req_ready = rstn && !full;
    assign push_vld  = req_valid && req_ready;
    assign push_dat  = '{write: req_write, sel: tgt_e'(req_sel), addr: req_addr, wdata: req_wdata};
    assign head_hold = (head.sel == TGT_FL) ? fl_hold : sp_hold;

    backdoor_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (req_t)
    ) u_req_fifo (
        .core_clk (clk),
        .rstn     (rstn),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop      (pop_vld),
        .pop_dat  (head),
        .full     (full),
        .empty    (empty)
    );

    always_comb begin
        state_d      = state_q;
        xfer_write_d = xfer_write_q;
        xfer_addr_d  = xfer_addr_q;
        xfer_wdata_d = xfer_wdata_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = rsp_err_q;
        rsp_rdata_d  = rsp_rdata_q;
        sp_en_d      = 1'b0;
        sp_write_d   = 1'b0;
        sp_mask_d    = 8'h00;
        sp_addr_d    = '0;
        sp_wdata_d   = 64'h0;
        fl_en_d      = 1'b0;
        fl_we_d      = 1'b0;
        fl_addr_d    = 32'h0;
        fl_wdata_d   = 8'h00;
        pop_vld      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty && !head_hold) begin
                    pop_vld      = 1'b1;
                    xfer_write_d = head.write;
                    xfer_addr_d  = head.addr;
                    xfer_wdata_d = head.wdata;
                    cnt_d        = 3'd0;
                    buf_d        = '0;
                    if (head.sel == TGT_FL) begin
                        state_d    = FL_XFER;
                        fl_en_d    = 1'b1;
                        fl_we_d    = head.write;
                        fl_addr_d  = head.addr;
                        fl_wdata_d = head.write ? head.wdata[7:0] : 8'h00;
                    end else if (head.addr[2:0] != 3'd0) begin
                        state_d     = RSP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 64'h0;
                    end else begin
                        state_d    = head.write ? SP_WR : SP_RD;
                        sp_en_d    = 1'b1;
                        sp_write_d = head.write;
                        sp_mask_d  = SP_FULL_MASK;
                        sp_addr_d  = head.addr[SP_ADDR_W+2:3];
                        sp_wdata_d = head.write ? head.wdata : 64'h0;
                    end
                end
            end
            SP_WR: begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = 64'h0;
            end
            SP_RD: state_d = SP_RDW;
            SP_RDW: begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = sp_rdata;
            end
            FL_XFER: begin
                // fl_rdata trails the byte address by one cycle.
                for (int b = 0; b < 7; b++) begin
                    if (!xfer_write_q && cnt_q == 3'(b + 1)) begin
                        buf_d[8*b +: 8] = fl_rdata;
                    end
                end
                if (cnt_q != 3'd7) begin
                    cnt_d      = cnt_q + 3'd1;
                    fl_en_d    = 1'b1;
                    fl_we_d    = xfer_write_q;
                    fl_addr_d  = xfer_addr_q + 32'(cnt_d);
                    fl_wdata_d = xfer_write_q ? xfer_wdata_q[{cnt_d, 3'b000} +: 8] : 8'h00;
                end else if (xfer_write_q) begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = 64'h0;
                end else begin
                    state_d = FL_RDW;
                end
            end
            FL_RDW: begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = {fl_rdata, buf_q};
            end
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            xfer_write_q <= 1'b0;
            xfer_addr_q  <= 32'h0;
            xfer_wdata_q <= 64'h0;
            cnt_q        <= 3'd0;
            buf_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= 64'h0;
            sp_en_q      <= 1'b0;
            sp_write_q   <= 1'b0;
            sp_mask_q    <= 8'h00;
            sp_addr_q    <= '0;
            sp_wdata_q   <= 64'h0;
            fl_en_q      <= 1'b0;
            fl_we_q      <= 1'b0;
            fl_addr_q    <= 32'h0;
            fl_wdata_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            xfer_write_q <= xfer_write_d;
            xfer_addr_q  <= xfer_addr_d;
            xfer_wdata_q <= xfer_wdata_d;
            cnt_q        <= cnt_d;
            buf_q        <= buf_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
            sp_en_q      <= sp_en_d;
            sp_write_q   <= sp_write_d;
            sp_mask_q    <= sp_mask_d;
            sp_addr_q    <= sp_addr_d;
            sp_wdata_q   <= sp_wdata_d;
            fl_en_q      <= fl_en_d;
            fl_we_q      <= fl_we_d;
            fl_addr_q    <= fl_addr_d;
            fl_wdata_q   <= fl_wdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign sp_en     = sp_en_q;
    assign sp_write  = sp_write_q;
    assign sp_mask   = sp_mask_q;
    assign sp_addr   = sp_addr_q;
    assign sp_wdata  = sp_wdata_q;
    assign fl_en     = fl_en_q;
    assign fl_we     = fl_we_q;
    assign fl_addr   = fl_addr_q;
    assign fl_wdata  = fl_wdata_q;

endmodule

// File: tb/tb_backdoor_mem_sequencer.sv
// Directed bench for backdoor_mem_sequencer with behavioural scratchpad and flash models.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_backdoor_mem_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready, req_write, req_sel;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid, rsp_err;
    logic [63:0] rsp_rdata;
    logic        sp_hold, fl_hold;
    logic        sp_en, sp_write;
    logic [7:0]  sp_mask;
    logic [15:0] sp_addr;
    logic [63:0] sp_wdata;
    logic [63:0] sp_rdata;
    logic        fl_en, fl_we;
    logic [31:0] fl_addr;
    logic [7:0]  fl_wdata;
    logic [7:0]  fl_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    backdoor_mem_sequencer #(.SP_ADDR_W(16), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_sel   (req_sel),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .sp_hold   (sp_hold),
        .fl_hold   (fl_hold),
        .sp_en     (sp_en),
        .sp_write  (sp_write),
        .sp_mask   (sp_mask),
        .sp_addr   (sp_addr),
        .sp_wdata  (sp_wdata),
        .sp_rdata  (sp_rdata),
        .fl_en     (fl_en),
        .fl_we     (fl_we),
        .fl_addr   (fl_addr),
        .fl_wdata  (fl_wdata),
        .fl_rdata  (fl_rdata)
    );

    // Memory models: registered, one-cycle read latency.
    logic [63:0] sp_mem [16];
    logic [7:0]  fl_mem [256];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sp_en && sp_write)  sp_mem[sp_addr[3:0]] <= sp_wdata;
        if (sp_en && !sp_write) sp_rdata <= sp_mem[sp_addr[3:0]];
        if (fl_en && fl_we)     fl_mem[fl_addr[7:0]] <= fl_wdata;
        if (fl_en && !fl_we)    fl_rdata <= fl_mem[fl_addr[7:0]];
    end

    // Monitor, sampled mid-cycle.
    int          rsp_cnt = 0, last_rsp_cyc = 0, sp_en_cnt = 0, sp_wr_cyc = 0, fl_wr_n = 0;
    logic [63:0] last_rsp_dat, sp_wr_dat;
    logic        last_rsp_err;
    logic [15:0] sp_wr_addr;
    logic [7:0]  sp_wr_mask;
    logic [31:0] fl_wr_addr [16];
    logic [7:0]  fl_wr_dat  [16];
    int          fl_wr_cyc  [16];
    logic [63:0] rsp_log [$];

    always @(negedge clk) begin
        if (rsp_valid) begin
            rsp_cnt++;
            last_rsp_cyc = cyc;
            last_rsp_dat = rsp_rdata;
            last_rsp_err = rsp_err;
            rsp_log.push_back(rsp_rdata);
        end
        if (sp_en) begin
            sp_en_cnt++;
            if (sp_write) begin
                sp_wr_cyc  = cyc;
                sp_wr_addr = sp_addr;
                sp_wr_mask = sp_mask;
                sp_wr_dat  = sp_wdata;
            end
        end
        if (fl_en && fl_we && fl_wr_n < 16) begin
            fl_wr_addr[fl_wr_n] = fl_addr;
            fl_wr_dat[fl_wr_n]  = fl_wdata;
            fl_wr_cyc[fl_wr_n]  = cyc;
            fl_wr_n++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic s, input logic [31:0] a,
                        input logic [63:0] d, output int acc);
        int n;
        n = 0;
        req_write = w; req_sel = s; req_addr = a; req_wdata = d; req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("send_timeout", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_rsp(input int target);
        int g;
        g = 0;
        while (rsp_cnt < target && g < 200) begin
            tick();
            g++;
        end
        chk("rsp_arrived", 64'(rsp_cnt >= target), 64'd1);
    endtask

    logic [63:0] hold_dat [5];

    initial begin
        int a, n0, se0, fw0;
        logic [31:0] ea;
        hold_dat[0] = 64'hC0DE_0001_0000_1001;
        hold_dat[1] = 64'hC0DE_0002_0000_2002;
        hold_dat[2] = 64'hC0DE_0003_0000_3003;
        hold_dat[3] = 64'hC0DE_0004_0000_4004;
        hold_dat[4] = 64'hC0DE_0005_0000_5005;
        for (int i = 0; i < 16; i++) sp_mem[i] = 64'h0;
        for (int i = 0; i < 5; i++) sp_mem[i+1] = hold_dat[i];
        for (int i = 0; i < 256; i++) fl_mem[i] = 8'h00;
        sp_rdata = 64'h0; fl_rdata = 8'h00;
        rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_sel = 1'b0;
        req_addr = 32'h0; req_wdata = 64'h0; sp_hold = 1'b0; fl_hold = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_outs", 64'(|{req_ready, rsp_valid, rsp_err, rsp_rdata, sp_en, sp_write, sp_mask,
                              sp_addr, sp_wdata, fl_en, fl_we, fl_addr, fl_wdata}), 64'd0);
        rstn = 1'b1;
        #1;
        chk("ready_after_rst", 64'(req_ready), 64'd1);
        tick();

        // Scratchpad write
        n0 = rsp_cnt; se0 = sp_en_cnt;
        send(1'b1, 1'b0, 32'h0000_0040, 64'hDEAD_BEEF_0123_4567, a);
        wait_rsp(n0 + 1);
        chk("spw_cyc", 64'(sp_wr_cyc), 64'(a + 1));
        chk("spw_addr", 64'(sp_wr_addr), 64'h8);
        chk("spw_mask", 64'(sp_wr_mask), 64'hFF);
        chk("spw_data", sp_wr_dat, 64'hDEAD_BEEF_0123_4567);
        chk("spw_en_cycles", 64'(sp_en_cnt - se0), 64'd1);
        chk("spw_rsp_cyc", 64'(last_rsp_cyc), 64'(a + 2));
        chk("spw_rsp_err", 64'(last_rsp_err), 64'd0);
        chk("spw_rsp_dat", last_rsp_dat, 64'h0);

        // Scratchpad read back
        n0 = rsp_cnt;
        send(1'b0, 1'b0, 32'h0000_0040, 64'h0, a);
        wait_rsp(n0 + 1);
        chk("spr_rsp_cyc", 64'(last_rsp_cyc), 64'(a + 3));
        chk("spr_rsp_dat", last_rsp_dat, 64'hDEAD_BEEF_0123_4567);
        chk("spr_rsp_err", 64'(last_rsp_err), 64'd0);
        repeat (4) tick();
        chk("rdata_held", rsp_rdata, 64'hDEAD_BEEF_0123_4567);
        chk("rsp_one_cycle", 64'(rsp_cnt), 64'(n0 + 1));

        // Misaligned scratchpad request
        n0 = rsp_cnt; se0 = sp_en_cnt;
        send(1'b0, 1'b0, 32'h0000_0044, 64'h0, a);
        wait_rsp(n0 + 1);
        chk("mis_rsp_cyc", 64'(last_rsp_cyc), 64'(a + 1));
        chk("mis_rsp_err", 64'(last_rsp_err), 64'd1);
        chk("mis_rsp_dat", last_rsp_dat, 64'h0);
        chk("mis_no_sp_en", 64'(sp_en_cnt - se0), 64'd0);

        // Flash write across the 2^32 wrap, fl_hold toggled mid-transfer
        n0 = rsp_cnt; fw0 = fl_wr_n;
        send(1'b1, 1'b1, 32'hFFFF_FFFC, 64'h8877_6655_4433_2211, a);
        repeat (3) tick();
        fl_hold = 1'b1;
        wait_rsp(n0 + 1);
        fl_hold = 1'b0;
        chk("flw_rsp_cyc", 64'(last_rsp_cyc), 64'(a + 9));
        chk("flw_rsp_err", 64'(last_rsp_err), 64'd0);
        chk("flw_rsp_dat", last_rsp_dat, 64'h0);
        chk("flw_count", 64'(fl_wr_n - fw0), 64'd8);
        chk("flw_first_cyc", 64'(fl_wr_cyc[fw0]), 64'(a + 1));
        for (int k = 0; k < 8; k++) begin
            ea = 32'hFFFF_FFFC + 32'(k);
            chk($sformatf("flw_addr%0d", k), 64'(fl_wr_addr[fw0+k]), 64'(ea));
            chk($sformatf("flw_byte%0d", k), 64'(fl_wr_dat[fw0+k]), 64'(8'h11 * (k + 1)));
        end

        // Flash read of the same bytes
        n0 = rsp_cnt;
        send(1'b0, 1'b1, 32'hFFFF_FFFC, 64'h0, a);
        wait_rsp(n0 + 1);
        chk("flr_rsp_cyc", 64'(last_rsp_cyc), 64'(a + 10));
        chk("flr_rsp_dat", last_rsp_dat, 64'h8877_6655_4433_2211);
        chk("flr_rsp_err", 64'(last_rsp_err), 64'd0);

        // Five SP reads queued behind sp_hold
        tick();
        n0 = rsp_cnt;
        rsp_log.delete();
        sp_hold = 1'b1;
        for (int k = 0; k < 4; k++) send(1'b0, 1'b0, 32'(8 * (k + 1)), 64'h0, a);
        chk("hold_full_ready", 64'(req_ready), 64'd0);
        req_write = 1'b0; req_sel = 1'b0; req_addr = 32'h0000_0028; req_valid = 1'b1;
        repeat (3) tick();
        chk("hold_still_full", 64'(req_ready), 64'd0);
        chk("hold_no_issue", 64'(rsp_cnt), 64'(n0));
        sp_hold = 1'b0;
        send(1'b0, 1'b0, 32'h0000_0028, 64'h0, a);
        wait_rsp(n0 + 5);
        chk("hold_rsp_count", 64'(rsp_log.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < rsp_log.size()) chk($sformatf("hold_order%0d", k), rsp_log[k], hold_dat[k]);
        end

        // Reset during byte 3 of a flash read
        tick();
        n0 = rsp_cnt;
        send(1'b0, 1'b1, 32'h0000_0010, 64'h0, a);
        while (cyc < a + 4) tick();
        chk("abort_byte3_addr", 64'(fl_addr), 64'h13);
        rstn = 1'b0;
        repeat (2) tick();
        chk("abort_outs", 64'(|{req_ready, rsp_valid, rsp_err, rsp_rdata, sp_en, sp_write, sp_mask,
                                sp_addr, sp_wdata, fl_en, fl_we, fl_addr, fl_wdata}), 64'd0);
        rstn = 1'b1;
        #1;
        chk("abort_ready", 64'(req_ready), 64'd1);
        repeat (15) tick();
        chk("abort_no_rsp", 64'(rsp_cnt), 64'(n0));
        send(1'b0, 1'b0, 32'h0000_0010, 64'h0, a);
        wait_rsp(n0 + 1);
        chk("post_abort_cyc", 64'(last_rsp_cyc), 64'(a + 3));
        chk("post_abort_dat", last_rsp_dat, hold_dat[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
